serial_alu_seq: RTL



---
 rtl/serial_alu_seq_if.sv | 25 ++
 rtl/serial_alu_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq_if.sv
// Handshake and operand/result bundle for serial_alu_seq.
// The slave modport is the ALU side, and the master modport is the requester side.
interface serial_alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic [1:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result;
    logic             o_cout;
    logic             o_ovf;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_result, o_cout, o_ovf
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_result, o_cout, o_ovf
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU that processes one bit per clock, LSB first, through a single 1-bit slice with a registered carry.
// Define SERIAL_ALU_OVF_EN to enable signed-overflow reporting; otherwise o_ovf is tied to 0.
module serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serial_alu_seq_if.slave bus
);
    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]     OP_ADD = 2'b00;
    localparam logic [1:0]     OP_SUB = 2'b01;
    localparam logic [1:0]     OP_AND = 2'b10;
    localparam logic [1:0]     OP_OR  = 2'b11;

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} state_t;

    // 1-bit slice primitives: full adder, and gate, or gate
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (c & (a ^ b));
    endfunction

    function automatic logic and_gate(input logic a, input logic b);
        return a & b;
    endfunction

    function automatic logic or_gate(input logic a, input logic b);
        return a | b;
    endfunction

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res_sh;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             w_last;
    logic             w_b_bit;
    logic             w_slice;
    logic             w_carry_next;
    logic             w_is_arith;

    // State register plus the busy/done flags, which are registered from the next state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == ST_RUN);
            r_done  <= (w_next_state == ST_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        w_last       = (r_cnt == LAST);
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Single 1-bit slice; for subtraction, B is inverted and the carry is seeded with 1
    always_comb begin
        w_is_arith   = ~r_op[1];
        w_b_bit      = (r_op == OP_SUB) ? ~r_b[0] : r_b[0];
        w_slice      = 1'b0;
        w_carry_next = r_carry;
        case (r_op)
            OP_ADD, OP_SUB: begin
                w_slice      = fa_sum(r_a[0], w_b_bit, r_carry);
                w_carry_next = fa_carry(r_a[0], w_b_bit, r_carry);
            end
            OP_AND:  w_slice = and_gate(r_a[0], r_b[0]);
            OP_OR:   w_slice = or_gate(r_a[0], r_b[0]);
            default: w_slice = 1'b0;
        endcase
    end

    // Operand/result shifting, bit counter and result capture on the RUN->DONE edge
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res_sh <= '0;
            r_op     <= 2'b00;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_a      <= bus.i_a;
                        r_b      <= bus.i_b;
                        r_op     <= bus.i_op;
                        r_carry  <= (bus.i_op == OP_SUB);
                        r_cnt    <= '0;
                        r_res_sh <= '0;
                    end
                end
                ST_RUN: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_res_sh <= {w_slice, r_res_sh[WIDTH-1:1]};
                    r_carry  <= w_carry_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_result <= {w_slice, r_res_sh[WIDTH-1:1]};
                        r_cout   <= w_is_arith & w_carry_next;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic r_carry_msb;
    logic r_ovf;

    // On the last RUN cycle, r_carry is the carry into the MSB; overflow is that XOR the carry out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_carry_msb <= 1'b0;
            r_ovf       <= 1'b0;
        end else if ((r_state == ST_RUN) && w_last) begin
            r_carry_msb <= r_carry;
            r_ovf       <= w_is_arith & (r_carry ^ w_carry_next);
        end else begin
            r_carry_msb <= r_carry_msb;
            r_ovf       <= r_ovf;
        end
    end

    assign bus.o_ovf = r_ovf;
`else
    assign bus.o_ovf = 1'b0;
`endif

    assign bus.o_busy   = r_busy;
    assign bus.o_done   = r_done;
    assign bus.o_result = r_result;
    assign bus.o_cout   = r_cout;
endmodule
